// File: rtl/gb_ppu_pkg.sv
// Shared PPU definitions: mode encoding, default LCD geometry, framebuffer entry
// layout and the BGP palette lookup.
package gb_ppu_pkg;

    localparam int unsigned LCD_WIDTH  = 160;
    localparam int unsigned LCD_HEIGHT = 144;
    localparam int unsigned FB_ADDR_W  = 15;
    localparam int unsigned SHADE_W    = 2;

    typedef enum logic [1:0] {
        H_BLANK = 2'd0,
        V_BLANK = 2'd1,
        SCAN    = 2'd2,
        DRAW    = 2'd3
    } ppu_mode_e;

    typedef struct packed {
        logic [FB_ADDR_W-1:0] addr;
        logic [SHADE_W-1:0]   shade;
    } fb_entry_t;

    // Colour index n selects BGP[2n+1:2n].
    function automatic logic [SHADE_W-1:0] bgp_shade(input logic [7:0] bgp,
                                                      input logic [1:0] idx);
        return bgp[{idx, 1'b0} +: SHADE_W];
    endfunction

endpackage

// File: rtl/lcd_px_fifo.sv
// Synchronous FIFO with wrap-bit pointers; a full FIFO accepts a push only
// when a pop happens in the same cycle.
module lcd_px_fifo #(
    parameter int unsigned DATA_W = 17,
    parameter int unsigned DEPTH  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [DATA_W-1:0]        wdata,
    input  logic                     pop,
    output logic [DATA_W-1:0]        rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              do_push;
    logic              do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count   = wr_ptr - rd_ptr;
    assign rdata   = mem[rd_ptr[AW-1:0]];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    // Storage needs no reset; empty pointers mask its contents.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/lcd_fb_writer.sv
// Captures DRAW-mode pixels, maps them through BGP and streams
// {address, shade} writes into the LCD framebuffer through a small FIFO.
module lcd_fb_writer
    import gb_ppu_pkg::*;
#(
    parameter int unsigned WIDTH      = LCD_WIDTH,
    parameter int unsigned HEIGHT     = LCD_HEIGHT,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           PX_IN,
    input  logic                 PX_valid,
    input  logic [1:0]           PPU_MODE,
    input  logic [7:0]           BGP,
    input  logic                 OVF_CLR,
    output logic                 FB_WR,
    output logic [FB_ADDR_W-1:0] FB_ADDR,
    output logic [SHADE_W-1:0]   FB_DATA,
    input  logic                 FB_READY,
    output logic                 FRAME_DONE,
    output logic                 OVERFLOW
);

    localparam int unsigned X_W   = $clog2(WIDTH + 1);
    localparam int unsigned Y_W   = $clog2(HEIGHT + 1);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic [1:0] {
        SYNC   = 2'd0,
        ACTIVE = 2'd1,
        DRAIN  = 2'd2,
        VBLANK = 2'd3
    } state_e;

    state_e               state;
    state_e               state_nxt;
    ppu_mode_e            mode;
    ppu_mode_e            prev_mode;
    logic [X_W-1:0]       x;
    logic [Y_W-1:0]       y;
    logic [FB_ADDR_W-1:0] addr;
    logic [FB_ADDR_W-1:0] line_base;
    logic                 capture_c;
    logic                 line_adv_c;
    logic                 frame_start_c;
    logic                 frame_done_c;
    logic                 push_drop_c;
    logic                 pop_c;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [CNT_W-1:0]     fifo_count;
    fb_entry_t            push_entry;
    fb_entry_t            head;

    assign mode = ppu_mode_e'(PPU_MODE);

    always_ff @(posedge clk) begin
        if (rst) state <= SYNC;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            SYNC:    if (mode == V_BLANK)    state_nxt = VBLANK;
            VBLANK:  if (mode != V_BLANK)    state_nxt = ACTIVE;
            ACTIVE:  if (mode == V_BLANK)    state_nxt = DRAIN;
            DRAIN:   if (fifo_count == '0)   state_nxt = VBLANK;
            default:                         state_nxt = SYNC;
        endcase
    end

    always_comb begin
        capture_c     = 1'b0;
        line_adv_c    = 1'b0;
        frame_start_c = 1'b0;
        frame_done_c  = 1'b0;
        case (state)
            ACTIVE: begin
                capture_c  = PX_valid && (mode == DRAW) &&
                             (x < X_W'(WIDTH)) && (y < Y_W'(HEIGHT));
                line_adv_c = (prev_mode == DRAW) && (mode == H_BLANK);
            end
            VBLANK:  frame_start_c = (mode != V_BLANK);
            DRAIN:   frame_done_c  = (fifo_count == '0);
            default: ;
        endcase
    end

    assign pop_c       = !fifo_empty && FB_READY;
    assign push_drop_c = capture_c && fifo_full && !pop_c;
    assign push_entry  = '{addr: addr, shade: bgp_shade(BGP, PX_IN)};

    // Position tracking: addr runs with x and steps by WIDTH per line.
    always_ff @(posedge clk) begin
        if (rst) begin
            x          <= '0;
            y          <= '0;
            addr       <= '0;
            line_base  <= '0;
            prev_mode  <= H_BLANK;
            FRAME_DONE <= 1'b0;
            OVERFLOW   <= 1'b0;
        end else begin
            prev_mode  <= mode;
            FRAME_DONE <= frame_done_c;
            if (push_drop_c)  OVERFLOW <= 1'b1;
            else if (OVF_CLR) OVERFLOW <= 1'b0;
            if (frame_start_c) begin
                x         <= '0;
                y         <= '0;
                addr      <= '0;
                line_base <= '0;
            end else if (capture_c) begin
                x    <= x + X_W'(1);
                addr <= addr + FB_ADDR_W'(1);
            end else if (line_adv_c) begin
                x <= '0;
                if (y < Y_W'(HEIGHT)) begin
                    y         <= y + Y_W'(1);
                    line_base <= line_base + FB_ADDR_W'(WIDTH);
                    addr      <= line_base + FB_ADDR_W'(WIDTH);
                end
            end
        end
    end

    lcd_px_fifo #(
        .DATA_W ($bits(fb_entry_t)),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (capture_c),
        .wdata (push_entry),
        .pop   (pop_c),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign FB_WR   = !fifo_empty;
    assign FB_ADDR = fifo_empty ? '0 : head.addr;
    assign FB_DATA = fifo_empty ? '0 : head.shade;

endmodule

// File: tb/tb_lcd_fb_writer.sv
// Directed bench for lcd_fb_writer: capture, palette, line advance, FIFO
// overflow, frame completion and mid-frame reset.
`timescale 1ns/1ps
module tb_lcd_fb_writer;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  PX_IN;
    logic        PX_valid;
    logic [1:0]  PPU_MODE;
    logic [7:0]  BGP;
    logic        OVF_CLR;
    logic        FB_WR;
    logic [14:0] FB_ADDR;
    logic [1:0]  FB_DATA;
    logic        FB_READY;
    logic        FRAME_DONE;
    logic        OVERFLOW;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int fd_count = 0;
    int fd_cyc   = -1;
    logic [14:0] wq_addr[$];
    logic [1:0]  wq_data[$];
    int          wq_cyc[$];

    always #5 clk = ~clk;

    lcd_fb_writer dut (
        .clk        (clk),
        .rst        (rst),
        .PX_IN      (PX_IN),
        .PX_valid   (PX_valid),
        .PPU_MODE   (PPU_MODE),
        .BGP        (BGP),
        .OVF_CLR    (OVF_CLR),
        .FB_WR      (FB_WR),
        .FB_ADDR    (FB_ADDR),
        .FB_DATA    (FB_DATA),
        .FB_READY   (FB_READY),
        .FRAME_DONE (FRAME_DONE),
        .OVERFLOW   (OVERFLOW)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Writes complete on the next posedge when both handshake lines are high here.
    always @(negedge clk) begin
        if (FB_WR === 1'b1 && FB_READY === 1'b1) begin
            wq_addr.push_back(FB_ADDR);
            wq_data.push_back(FB_DATA);
            wq_cyc.push_back(cyc);
        end
        if (FRAME_DONE === 1'b1) begin
            fd_count++;
            fd_cyc = cyc;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        wq_addr.delete();
        wq_data.delete();
        wq_cyc.delete();
        fd_count = 0;
        fd_cyc   = -1;
    endtask

    task automatic drive_line(input int n, input logic [1:0] idx);
        PPU_MODE = 2'd2; tick();
        PPU_MODE = 2'd3; tick();
        for (int i = 0; i < n; i++) begin
            PX_IN = idx; PX_valid = 1'b1; tick();
        end
        PX_valid = 1'b0;
        PPU_MODE = 2'd0; tick(); tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; PX_IN = '0; PX_valid = 1'b0; PPU_MODE = 2'd0;
        BGP = 8'hE4; OVF_CLR = 1'b0; FB_READY = 1'b1;
        tick(); tick();
        total++; if (FB_WR !== 1'b0)      begin bad++; $display("FAIL rst_fb_wr: got %0d expected 0", FB_WR); end
        total++; if (FB_ADDR !== 15'd0)   begin bad++; $display("FAIL rst_fb_addr: got %0d expected 0", FB_ADDR); end
        total++; if (FB_DATA !== 2'd0)    begin bad++; $display("FAIL rst_fb_data: got %0d expected 0", FB_DATA); end
        total++; if (FRAME_DONE !== 1'b0) begin bad++; $display("FAIL rst_frame_done: got %0d expected 0", FRAME_DONE); end
        total++; if (OVERFLOW !== 1'b0)   begin bad++; $display("FAIL rst_overflow: got %0d expected 0", OVERFLOW); end
        rst = 1'b0;
        clear_log();
        PPU_MODE = 2'd3; PX_IN = 2'd1; PX_valid = 1'b1;
        repeat (5) tick();
        PX_valid = 1'b0; tick(); tick();
        total++; if (wq_addr.size() !== 0) begin bad++; $display("FAIL sync_discard: got %0d writes expected 0", wq_addr.size()); end
    endtask

    task automatic test_first_line();
        int errs = 0;
        int first_bad = -1;
        clear_log();
        BGP = 8'hE4;
        PPU_MODE = 2'd1; tick(); tick();
        PPU_MODE = 2'd2; tick();
        PPU_MODE = 2'd3; PX_IN = 2'd1; PX_valid = 1'b1;
        total++; if (FB_WR !== 1'b0) begin bad++; $display("FAIL latency_pre: got %0d expected 0", FB_WR); end
        tick();
        total++;
        if (FB_WR !== 1'b1 || FB_ADDR !== 15'd0 || FB_DATA !== 2'd1) begin
            bad++; $display("FAIL latency_1cyc: got wr=%0d addr=%0d data=%0d expected 1/0/1", FB_WR, FB_ADDR, FB_DATA);
        end
        repeat (159) tick();
        PX_valid = 1'b0; PPU_MODE = 2'd0;
        tick(); tick(); tick();
        total++; if (wq_addr.size() !== 160) begin bad++; $display("FAIL line0_count: got %0d expected 160", wq_addr.size()); end
        for (int i = 0; i < wq_addr.size() && i < 160; i++) begin
            if (wq_addr[i] !== 15'(i) || wq_data[i] !== 2'd1) begin
                errs++; if (first_bad < 0) first_bad = i;
            end
        end
        total++; if (errs !== 0) begin bad++; $display("FAIL line0_entries: got %0d bad entries (first %0d) expected 0", errs, first_bad); end
    endtask

    task automatic test_full_frame();
        int errs = 0;
        int first_bad = -1;
        clear_log();
        for (int y = 1; y < 144; y++) drive_line(160, 2'(y % 4));
        total++; if (wq_addr.size() !== 143 * 160) begin bad++; $display("FAIL frame_count: got %0d expected %0d", wq_addr.size(), 143 * 160); end
        for (int i = 0; i < wq_addr.size(); i++) begin
            if (wq_addr[i] !== 15'(160 + i) || wq_data[i] !== 2'(((160 + i) / 160) % 4)) begin
                errs++; if (first_bad < 0) first_bad = i;
            end
        end
        total++; if (errs !== 0) begin bad++; $display("FAIL frame_entries: got %0d bad entries (first %0d) expected 0", errs, first_bad); end
        PPU_MODE = 2'd1;
        for (int i = 0; i < 40 && fd_count == 0; i++) tick();
        total++; if (fd_count !== 1) begin bad++; $display("FAIL frame_done_seen: got %0d pulses expected 1", fd_count); end
        total++; if (wq_addr.size() == 0 || wq_addr[$] !== 15'd23039) begin bad++; $display("FAIL frame_last_addr: got %0d expected 23039", (wq_addr.size() == 0) ? -1 : int'(wq_addr[$])); end
        total++; if (wq_cyc.size() == 0 || fd_cyc <= wq_cyc[$]) begin bad++; $display("FAIL frame_done_order: got done cycle %0d expected after last write", fd_cyc); end
        repeat (10) tick();
        total++; if (fd_count !== 1) begin bad++; $display("FAIL frame_done_single: got %0d pulses expected 1", fd_count); end
    endtask

    task automatic test_palette();
        logic [1:0] exp_data [5];
        int errs = 0;
        exp_data = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd3};
        clear_log();
        BGP = 8'h1B;
        PPU_MODE = 2'd2; tick();
        PPU_MODE = 2'd3; tick();
        for (int i = 0; i < 4; i++) begin
            PX_IN = 2'(i); PX_valid = 1'b1; tick();
        end
        BGP = 8'hE4; PX_IN = 2'd3; tick();
        PX_valid = 1'b0; tick(); tick(); tick();
        total++; if (wq_addr.size() !== 5) begin bad++; $display("FAIL palette_count: got %0d expected 5", wq_addr.size()); end
        for (int i = 0; i < wq_addr.size() && i < 5; i++)
            if (wq_addr[i] !== 15'(i) || wq_data[i] !== exp_data[i]) errs++;
        total++; if (errs !== 0) begin bad++; $display("FAIL palette_entries: got %0d bad entries expected 0", errs); end
        PPU_MODE = 2'd1;
        for (int i = 0; i < 40 && fd_count == 0; i++) tick();
        total++; if (fd_count !== 1) begin bad++; $display("FAIL palette_frame_done: got %0d expected 1", fd_count); end
    endtask

    task automatic test_line_advance();
        clear_log();
        BGP = 8'hE4;
        drive_line(100, 2'd2);
        PPU_MODE = 2'd2; tick();
        PPU_MODE = 2'd3; PX_IN = 2'd3; PX_valid = 1'b1; tick();
        PX_valid = 1'b0; tick(); tick();
        total++; if (wq_addr.size() !== 101) begin bad++; $display("FAIL short_line_count: got %0d expected 101", wq_addr.size()); end
        total++; if (wq_addr.size() < 101 || wq_addr[99] !== 15'd99) begin bad++; $display("FAIL short_line_last: got %0d expected 99", (wq_addr.size() < 100) ? -1 : int'(wq_addr[99])); end
        total++; if (wq_addr.size() < 101 || wq_addr[100] !== 15'd160 || wq_data[100] !== 2'd3) begin bad++; $display("FAIL line1_first: got %0d expected addr 160 data 3", (wq_addr.size() < 101) ? -1 : int'(wq_addr[100])); end
    endtask

    task automatic test_overflow();
        int errs = 0;
        clear_log();
        FB_READY = 1'b0;
        for (int i = 0; i < 10; i++) begin
            PX_IN = 2'(i % 4); PX_valid = 1'b1; tick();
        end
        PX_valid = 1'b0; tick();
        total++; if (FB_WR !== 1'b1 || FB_ADDR !== 15'd161 || FB_DATA !== 2'd0) begin bad++; $display("FAIL ovf_hold_head: got wr=%0d addr=%0d data=%0d expected 1/161/0", FB_WR, FB_ADDR, FB_DATA); end
        total++; if (OVERFLOW !== 1'b1) begin bad++; $display("FAIL ovf_set: got %0d expected 1", OVERFLOW); end
        total++; if (wq_addr.size() !== 0) begin bad++; $display("FAIL ovf_stalled: got %0d writes expected 0", wq_addr.size()); end
        FB_READY = 1'b1;
        repeat (12) tick();
        total++; if (wq_addr.size() !== 8) begin bad++; $display("FAIL ovf_held_count: got %0d expected 8", wq_addr.size()); end
        for (int i = 0; i < wq_addr.size() && i < 8; i++)
            if (wq_addr[i] !== 15'(161 + i) || wq_data[i] !== 2'(i % 4)) errs++;
        total++; if (errs !== 0) begin bad++; $display("FAIL ovf_order: got %0d bad entries expected 0", errs); end
        total++; if (OVERFLOW !== 1'b1) begin bad++; $display("FAIL ovf_sticky: got %0d expected 1", OVERFLOW); end
        OVF_CLR = 1'b1; tick(); OVF_CLR = 1'b0;
        total++; if (OVERFLOW !== 1'b0) begin bad++; $display("FAIL ovf_clear: got %0d expected 0", OVERFLOW); end
        FB_READY = 1'b0;
        for (int i = 0; i < 8; i++) begin
            PX_IN = 2'd1; PX_valid = 1'b1; tick();
        end
        OVF_CLR = 1'b1; tick();
        OVF_CLR = 1'b0; PX_valid = 1'b0;
        total++; if (OVERFLOW !== 1'b1) begin bad++; $display("FAIL ovf_set_wins: got %0d expected 1", OVERFLOW); end
        FB_READY = 1'b1;
        repeat (10) tick();
        OVF_CLR = 1'b1; tick(); OVF_CLR = 1'b0;
        clear_log();
        PPU_MODE = 2'd1;
        for (int i = 0; i < 40 && fd_count == 0; i++) tick();
        total++; if (fd_count !== 1) begin bad++; $display("FAIL ovf_frame_done: got %0d expected 1", fd_count); end
    endtask

    task automatic test_reset_mid_frame();
        clear_log();
        for (int y = 0; y < 50; y++) drive_line(1, 2'd0);
        PPU_MODE = 2'd2; tick();
        PPU_MODE = 2'd3; tick();
        FB_READY = 1'b0;
        for (int i = 0; i < 3; i++) begin
            PX_IN = 2'd1; PX_valid = 1'b1; tick();
        end
        PX_valid = 1'b0;
        total++; if (FB_WR !== 1'b1 || FB_ADDR !== 15'd8000) begin bad++; $display("FAIL mid_queued: got wr=%0d addr=%0d expected 1/8000", FB_WR, FB_ADDR); end
        clear_log();
        rst = 1'b1; tick(); rst = 1'b0;
        total++; if (FB_WR !== 1'b0) begin bad++; $display("FAIL mid_rst_wr: got %0d expected 0", FB_WR); end
        FB_READY = 1'b1;
        drive_line(20, 2'd1);
        drive_line(20, 2'd2);
        total++; if (wq_addr.size() !== 0) begin bad++; $display("FAIL mid_ignored: got %0d writes expected 0", wq_addr.size()); end
        PPU_MODE = 2'd1; tick(); tick();
        PPU_MODE = 2'd2; tick();
        PPU_MODE = 2'd3; PX_IN = 2'd2; PX_valid = 1'b1; tick();
        PX_valid = 1'b0; tick(); tick();
        total++; if (wq_addr.size() !== 1 || wq_addr[0] !== 15'd0 || wq_data[0] !== 2'd2) begin bad++; $display("FAIL mid_resync: got %0d writes first addr %0d expected 1 write at 0 data 2", wq_addr.size(), (wq_addr.size() == 0) ? -1 : int'(wq_addr[0])); end
    endtask

    initial begin
        test_reset();
        test_first_line();
        test_full_frame();
        test_palette();
        test_line_advance();
        test_overflow();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lcd_fb_writer.md
LCD_FB_WRITER -- requirements
Module: lcd_fb_writer

Interface
REQ-001 Parameters SHALL be: WIDTH, default 160, visible pixels per line; HEIGHT, default 144, visible lines per frame; FIFO_DEPTH, default 8, pixel FIFO entries (power of two).
REQ-002 clk  in  1  single system clock; all logic on posedge clk.
REQ-003 rst  in  1  reset, synchronous and active-high.
REQ-004 PX_IN  in  2  raw 2-bit colour index from the pixel shifter.
REQ-005 PX_valid  in  1  PX_IN is valid this cycle; no backpressure is available to the source.
REQ-006 PPU_MODE  in  2  PPU mode: 0 H_BLANK, 1 V_BLANK, 2 SCAN, 3 DRAW.
REQ-007 BGP  in  8  palette register; index n maps to shade BGP[2n+1:2n].
REQ-008 OVF_CLR  in  1  one-cycle pulse that clears OVERFLOW.
REQ-009 FB_WR  out  1  framebuffer write request.
REQ-010 FB_ADDR  out  15  framebuffer address, y*WIDTH+x.
REQ-011 FB_DATA  out  2  shade to write.
REQ-012 FB_READY  in  1  the write completes in any cycle where FB_WR and FB_READY are both high.
REQ-013 FRAME_DONE  out  1  one-cycle pulse when a frame is fully written.
REQ-014 OVERFLOW  out  1  sticky flag: a pixel was dropped because the FIFO was full.

Function
REQ-015 FSM states SHALL be SYNC, ACTIVE, DRAIN and VBLANK.
REQ-016 SYNC SHALL discard all pixels and move to VBLANK when PPU_MODE==1.
REQ-017 VBLANK SHALL move to ACTIVE when PPU_MODE!=1, with x=0 and y=0.
REQ-018 In ACTIVE, a pixel SHALL be captured only when PX_valid && PPU_MODE==3 && x<WIDTH && y<HEIGHT; other valid pixels are dropped silently, without setting OVERFLOW.
REQ-019 A capture SHALL push the entry {addr, BGP shade of PX_IN} into the FIFO, with BGP sampled in the same cycle, and SHALL increment x.
REQ-020 In ACTIVE, the PPU_MODE transition 3->0 (seen via a registered previous mode) SHALL set x=0 and y=y+1; y saturates at HEIGHT.
REQ-021 addr SHALL be held as a running register: +1 per capture, and set to (y+1)*WIDTH on a line advance, using an incremental add of WIDTH with no multiplier.
REQ-022 In ACTIVE, PPU_MODE==1 SHALL move the FSM to DRAIN; DRAIN SHALL accept no captures.
REQ-023 DRAIN SHALL, in the first cycle the FIFO is empty and no write is in flight, pulse FRAME_DONE for 1 cycle and move to VBLANK.
REQ-024 FB_WR SHALL be high iff the FIFO is non-empty; FB_ADDR and FB_DATA SHALL show the head entry and hold stable until accepted.
REQ-025 A pop SHALL occur on FB_WR && FB_READY; the next entry SHALL be presented the following cycle, giving 1 write per cycle with FB_READY held high.
REQ-026 Push/pop rules SHALL be:
- Push and pop in the same cycle on a full FIFO: both accepted, count unchanged.
- Push and pop in the same cycle on an empty FIFO: the entry goes through the storage with 1-cycle latency; bypass is not required.
REQ-027 Push on a full FIFO with no pop SHALL drop the pixel and set OVERFLOW, which stays set until OVF_CLR; if set and clear occur in the same cycle, set wins.
REQ-028 Capture-to-FB_WR latency SHALL be 1 cycle when the FIFO is empty.
REQ-029 FIFO pointers SHALL be log2(FIFO_DEPTH)+1 bits wide, with full/empty determined by MSB compare; pointers wrap.

Reset
REQ-030 rst SHALL force: FSM=SYNC; x=0, y=0, addr=0; FIFO empty; FB_WR=0, FB_ADDR=0, FB_DATA=0; FRAME_DONE=0; OVERFLOW=0; previous mode=0.
REQ-031 rst asserted mid-frame SHALL discard FIFO contents with no further writes, and resynchronise only at the next V_BLANK.

Structure
REQ-032 The PPU mode enum (H_BLANK=0, V_BLANK=1, SCAN=2, DRAW=3) and the default LCD WIDTH/HEIGHT constants SHALL reside in the shared package gb_ppu_pkg; the FSM typedef SHALL be local.
REQ-033 The FIFO SHALL be a separate sub-module, lcd_px_fifo: parameterised data width and depth, with push/pop/full/empty/count ports.

Verification
REQ-034 Reset, mode 1, then mode 2 -> 3 with 160 valid pixels of index 1 and BGP=0xE4, FB_READY=1 -> 160 writes to addr 0..159, each with data 1.
REQ-035 Complete 144-line frame followed by mode=1 -> last write at addr 23039, then exactly one FRAME_DONE pulse, then FSM in VBLANK.
REQ-036 BGP=0x1B, indices 0,1,2,3 -> data 3,2,1,0.
REQ-037 FB_READY=0 during 10 consecutive captures -> 8 entries held, OVERFLOW=1, the first 8 written in order once FB_READY=1; OVF_CLR -> OVERFLOW=0.
REQ-038 Line 0 with only 100 pixels, then a 3->0 transition -> the first pixel of line 1 is written to addr 160.
REQ-039 rst asserted at line 50 with 3 entries queued -> FB_WR=0 the next cycle; pixels ignored until mode=1, then the next frame starts at addr 0.
